// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - resolves a carry-save sum/carry pair into binary, CHUNK_W bits per cycle
module csa_resolver #(
  parameter int DATA_W  = 24,
  parameter int CHUNK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_sum,
  input  logic [DATA_W-1:0] i_carry,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W:0]   o_data,
  output logic              o_busy
);

  localparam int NCHUNK   = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int O_DATA_W = DATA_W + 1;
  localparam int KW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Covers one chunk plus the bit above it, where the provisional carry-out lands.
  // The next chunk overwrites that bit; after the last chunk it is the final carry-out.
  localparam logic [O_DATA_W-1:0] CHUNK_MASK = O_DATA_W'({(CHUNK_W + 1){1'b1}});

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic                cin_q, cin_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   carry_q, carry_d;
  logic [O_DATA_W-1:0] data_q, data_d;

  logic [31:0]         chunk_off;
  logic [CHUNK_W-1:0]  a_chunk, b_chunk;
  logic [CHUNK_W:0]    chunk_sum;
  logic [O_DATA_W-1:0] data_merged;
  logic                accept;

  // Chunk datapath: the slice of both operands at chunk k plus the registered carry-in.
  // Bits past DATA_W shift in as zero, so a partial last chunk puts its carry at bit DATA_W.
  always_comb begin
    chunk_off   = 32'(k_q) * 32'(CHUNK_W);
    a_chunk     = CHUNK_W'(sum_q >> chunk_off);
    b_chunk     = CHUNK_W'(carry_q >> chunk_off);
    chunk_sum   = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK_W + 1)'(cin_q);
    data_merged = (data_q & ~(CHUNK_MASK << chunk_off)) | (O_DATA_W'(chunk_sum) << chunk_off);
  end

  // Next-state and handshake logic for the IDLE / ADD / DONE sequencer
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    data_d  = data_q;
    i_ready = (state_q == IDLE) || ((state_q == DONE) && o_ready);
    accept  = i_valid && i_ready;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = ADD;
          k_d     = '0;
          cin_d   = 1'b0;
          sum_d   = i_sum;
          carry_d = i_carry;
          data_d  = '0;
        end else if (state_q == DONE && o_ready) begin
          state_d = IDLE;
        end
      end
      ADD: begin
        data_d = data_merged;
        cin_d  = chunk_sum[CHUNK_W];
        if (k_q == KW'(NCHUNK - 1)) begin
          state_d = DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q == ADD);
  assign o_data  = data_q;

  // State registers; reset wins over any handshake on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: doc/csa_resolver.md
CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, giving the width of the carry-save sum and carry vectors.
REQ-002 The block SHALL have parameter CHUNK_W, default 8, giving the bits resolved per cycle, legal range 1..DATA_W.
REQ-003 The block SHALL derive localparam NCHUNK = ceil(DATA_W/CHUNK_W) and localparam O_DATA_W = DATA_W+1.
REQ-004 The block SHALL use one clock, clk, with all state updating on its rising edge.
REQ-005 clk  input  1  sole clock.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 i_valid  input  1  the carry-save operand pair is valid.
REQ-008 i_ready  output  1  the block can accept an operand pair.
REQ-009 i_sum  input  DATA_W  carry-save sum vector.
REQ-010 i_carry  input  DATA_W  carry-save carry vector, already weighted (added as-is, no shift).
REQ-011 o_valid  output  1  the result is valid.
REQ-012 o_ready  input  1  downstream accepts the result.
REQ-013 o_data  output  O_DATA_W  binary result, i_sum + i_carry, with the carry-out in the MSB.
REQ-014 o_busy  output  1  high while in state ADD.

Function
REQ-015 The FSM SHALL have states IDLE, ADD and DONE.
REQ-016 A transfer SHALL occur on a rising edge when i_valid and i_ready are both 1; the block SHALL capture i_sum and i_carry into internal registers on that edge.
REQ-017 i_ready SHALL be 1 in IDLE, 1 in DONE only while o_ready=1, and 0 in ADD.
REQ-018 On acceptance, the FSM SHALL go to ADD with chunk index 0 and carry-in 0.
REQ-019 Each ADD cycle SHALL add chunk k (bits k*CHUNK_W upward) of both operands plus the registered carry-in.
- It SHALL store the chunk result into o_data.
- It SHALL register the chunk carry-out as the next carry-in.
- It SHALL increment k.
REQ-020 The last chunk MAY be partial, with width DATA_W-(NCHUNK-1)*CHUNK_W; its carry-out SHALL be written to o_data[DATA_W].
REQ-021 After the edge that processes chunk NCHUNK-1, the FSM SHALL be in DONE with o_valid=1.
- Latency SHALL be exactly NCHUNK edges after the accepting edge (3 for the defaults).
REQ-022 In DONE, o_valid and o_data SHALL hold stable until an edge with o_ready=1.
REQ-023 On an edge in DONE with o_ready=1:
- If i_valid=0, the FSM SHALL go to IDLE and o_valid SHALL fall.
- If i_valid=1, the block SHALL accept the new pair and go directly to ADD, with o_valid falling. This gives back-to-back throughput of one result per NCHUNK+1 cycles.
REQ-024 i_valid, i_sum and i_carry SHALL be ignored while in ADD, and the captured operands SHALL NOT change.
REQ-025 The arithmetic SHALL be unsigned modulo 2^O_DATA_W, so no overflow is possible.
REQ-026 When CHUNK_W=DATA_W, NCHUNK SHALL be 1 and the latency SHALL be 1 cycle.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL enter IDLE, set the chunk index and carry-in to 0, and clear the operand registers.
REQ-028 Reset values SHALL be o_valid=0, o_busy=0, o_data=0 and i_ready=1 (i_ready is 1 in the first cycle after the reset edge).
REQ-029 Reset SHALL have priority over every other event, including acceptance in the same cycle.
REQ-030 Reset in ADD or DONE SHALL abort the operation; the aborted result SHALL never be presented and no further o_valid SHALL assert for it.

Verification
REQ-031 The bench SHALL cover carry ripple across all chunks: defaults, i_sum=0xFFFFFF, i_carry=0x000001 -> o_valid exactly 3 cycles after acceptance, o_data=0x1000000.
REQ-032 The bench SHALL cover the mid-chunk carry: i_sum=0x0000FF, i_carry=0x000001 -> o_data=0x0000100; and i_sum=0x123456, i_carry=0x654321 -> o_data=0x0777777.
REQ-033 The bench SHALL cover backpressure: o_ready=0 for 5 cycles after o_valid -> o_data held constant, i_ready=0, a new i_valid is not accepted; o_ready=1 -> the handshake completes in one cycle.
REQ-034 The bench SHALL cover back-to-back transfers: i_valid held high with 4 operand pairs and o_ready=1 -> 4 correct results, spaced 4 cycles apart, in order.
REQ-035 The bench SHALL cover reset mid-operation: rst pulsed 1 cycle in the 2nd ADD cycle -> o_valid stays 0, the next cycle shows i_ready=1 and o_data=0, and the next transfer computes correctly.
REQ-036 The bench SHALL cover a partial chunk: DATA_W=20, CHUNK_W=8, i_sum=0xFFFFF, i_carry=0xFFFFF -> latency 3 cycles, o_data=0x1FFFFE.
REQ-037 The bench SHALL include a random test of at least 10k pairs against a reference model, with random o_ready.
